// File: rtl/fanout_eager_fork_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fanout_eager_fork_pkg: shared state type and default sizing        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package fanout_eager_fork_pkg;

  localparam int DEF_NUM_CH = 6;
  localparam int DEF_SEL_W  = 32;
  localparam int DEF_CNT_W  = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } fork_state_t;

  // Width of a bit index into a select word; never narrower than one bit.
  function automatic int sel_idx_w(input int sel_w);
    return (sel_w > 1) ? $clog2(sel_w) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fanout_sel_decode.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fanout_sel_decode: per-channel live participation from select bits |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module fanout_sel_decode
  import fanout_eager_fork_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int SEL_W  = DEF_SEL_W,
  parameter int IDX_W  = sel_idx_w(DEF_SEL_W)
) (
  input  logic [NUM_CH-1:0]       i_cfg_en,
  input  logic [NUM_CH*IDX_W-1:0] i_cfg_sel_idx,
  input  logic [NUM_CH*SEL_W-1:0] i_sel_word,
  output logic [NUM_CH-1:0]       o_live
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [SEL_W-1:0] w_word;
    logic [IDX_W-1:0] w_idx;
    logic             w_in_range;

    assign w_word     = i_sel_word[i*SEL_W +: SEL_W];
    assign w_idx      = i_cfg_sel_idx[i*IDX_W +: IDX_W];
    // Indices past the end of the word mark the channel as not taking part.
    assign w_in_range = ({1'b0, w_idx} < (IDX_W+1)'(SEL_W));
    assign o_live[i]  = i_cfg_en[i] & w_in_range & w_word[w_idx];
  end

endmodule
`default_nettype wire

// File: rtl/fanout_eager_fork.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fanout_eager_fork: one-to-many token fork, eager or lazy delivery  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module fanout_eager_fork
  import fanout_eager_fork_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int SEL_W  = DEF_SEL_W,
  parameter int CNT_W  = DEF_CNT_W,
  localparam int IDX_W = sel_idx_w(SEL_W)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    up_valid,
  output logic                    up_ready,
  input  logic [NUM_CH*SEL_W-1:0] sel_word,
  input  logic [NUM_CH-1:0]       cfg_en,
  input  logic [NUM_CH*IDX_W-1:0] cfg_sel_idx,
  input  logic                    cfg_eager,
  output logic [NUM_CH-1:0]       down_valid,
  input  logic [NUM_CH-1:0]       down_ready,
  output logic                    busy,
  output logic [CNT_W-1:0]        xfer_cnt
);

  fork_state_t       r_state;
  fork_state_t       w_state_nxt;
  logic [NUM_CH-1:0] r_done;
  logic [NUM_CH-1:0] r_mask_q;
  logic [CNT_W-1:0]  r_cnt;

  logic [NUM_CH-1:0] w_live;
  logic [NUM_CH-1:0] w_mask;
  logic [NUM_CH-1:0] w_ok;
  logic [NUM_CH-1:0] w_others;
  logic [NUM_CH-1:0] w_lazy_dv;
  logic [NUM_CH-1:0] w_accept;
  logic              w_eager;
  logic              w_fire;

  fanout_sel_decode #(
    .NUM_CH (NUM_CH),
    .SEL_W  (SEL_W),
    .IDX_W  (IDX_W)
  ) u_sel_decode (
    .i_cfg_en      (cfg_en),
    .i_cfg_sel_idx (cfg_sel_idx),
    .i_sel_word    (sel_word),
    .o_live        (w_live)
  );

  assign w_mask = (r_state == PEND) ? r_mask_q : w_live;
  // PEND is only reachable in eager mode, so it pins the mode until the token ends.
  assign w_eager = (r_state == PEND) | cfg_eager;
  assign w_ok    = ~w_mask | down_ready;

  always_comb begin
    w_others  = '0;
    w_lazy_dv = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_others     = w_ok;
      w_others[i]  = 1'b1;
      w_lazy_dv[i] = &w_others;
    end
  end

  assign down_valid = w_eager ? ({NUM_CH{up_valid}} & w_mask & ~r_done)
                              : ({NUM_CH{up_valid}} & w_mask & w_lazy_dv);
  assign up_ready   = &(~w_mask | r_done | down_ready);
  assign w_fire     = up_valid & up_ready;
  assign w_accept   = down_valid & down_ready;
  assign busy       = (r_state == PEND);
  assign xfer_cnt   = r_cnt;

  always_comb begin
    w_state_nxt = r_state;
    if (w_fire) begin
      w_state_nxt = IDLE;
    end else if (up_valid && w_eager && (|w_accept)) begin
      w_state_nxt = PEND;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_done   <= '0;
      r_mask_q <= '0;
      r_cnt    <= '0;
    end else if (w_fire) begin
      r_done <= '0;
      r_cnt  <= r_cnt + CNT_W'(1);
    end else if (up_valid && w_eager) begin
      r_done <= r_done | w_accept;
      if ((r_state == IDLE) && (|w_accept)) begin
        r_mask_q <= w_mask;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fanout_eager_fork.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fanout_eager_fork: directed and randomized checks vs token model|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_fanout_eager_fork;

  logic         clk;
  logic         rst_n;
  logic         up_valid;
  logic         up_ready;
  logic [191:0] sel_word;
  logic [5:0]   cfg_en;
  logic [29:0]  cfg_sel_idx;
  logic         cfg_eager;
  logic [5:0]   down_valid;
  logic [5:0]   down_ready;
  logic         busy;
  logic [15:0]  xfer_cnt;

  logic         b_up_valid;
  logic         b_up_ready;
  logic [119:0] b_sel_word;
  logic [5:0]   b_cfg_en;
  logic [29:0]  b_cfg_sel_idx;
  logic         b_cfg_eager;
  logic [5:0]   b_down_valid;
  logic [5:0]   b_down_ready;
  logic         b_busy;
  logic [3:0]   b_xfer_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  fanout_eager_fork u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .up_valid    (up_valid),
    .up_ready    (up_ready),
    .sel_word    (sel_word),
    .cfg_en      (cfg_en),
    .cfg_sel_idx (cfg_sel_idx),
    .cfg_eager   (cfg_eager),
    .down_valid  (down_valid),
    .down_ready  (down_ready),
    .busy        (busy),
    .xfer_cnt    (xfer_cnt)
  );

  fanout_eager_fork #(.NUM_CH(6), .SEL_W(20), .CNT_W(4)) u_dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .up_valid    (b_up_valid),
    .up_ready    (b_up_ready),
    .sel_word    (b_sel_word),
    .cfg_en      (b_cfg_en),
    .cfg_sel_idx (b_cfg_sel_idx),
    .cfg_eager   (b_cfg_eager),
    .down_valid  (b_down_valid),
    .down_ready  (b_down_ready),
    .busy        (b_busy),
    .xfer_cnt    (b_xfer_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Token-level model: which channels the current token needs, which already have it.
  bit       m_inflight;
  bit [5:0] m_need;
  bit [5:0] m_got;
  int       m_cnt;
  bit [5:0] e_need;
  bit [5:0] e_dv;
  bit       e_ur;
  bit       e_eag;

  task automatic model_expect();
    bit ok;
    for (int i = 0; i < 6; i++) begin
      if (m_inflight) e_need[i] = m_need[i];
      else e_need[i] = cfg_en[i] && sel_word[i*32 + int'(cfg_sel_idx[i*5 +: 5])];
    end
    e_eag = m_inflight || cfg_eager;
    e_ur  = 1'b1;
    for (int i = 0; i < 6; i++)
      if (e_need[i] && !m_got[i] && !down_ready[i]) e_ur = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (e_eag) begin
        e_dv[i] = up_valid && e_need[i] && !m_got[i];
      end else begin
        ok = 1'b1;
        for (int j = 0; j < 6; j++)
          if (j != i && e_need[j] && !down_ready[j]) ok = 1'b0;
        e_dv[i] = up_valid && e_need[i] && ok;
      end
    end
  endtask

  task automatic tick();
    bit any;
    @(posedge clk);
    model_expect();
    if (!rst_n) begin
      m_inflight = 0; m_need = '0; m_got = '0; m_cnt = 0;
    end else if (up_valid && e_ur) begin
      m_cnt = (m_cnt + 1) % 65536; m_inflight = 0; m_got = '0;
    end else if (up_valid && e_eag) begin
      any = 0;
      for (int i = 0; i < 6; i++)
        if (e_dv[i] && down_ready[i]) begin m_got[i] = 1; any = 1; end
      if (any && !m_inflight) begin m_inflight = 1; m_need = e_need; end
    end
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; up_valid = 1'b0; b_up_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic set_all_sel(input bit v);
    sel_word    = v ? '1 : '0;
    cfg_sel_idx = '0;
    for (int i = 0; i < 6; i++) cfg_sel_idx[i*5 +: 5] = 5'($urandom_range(0, 31));
  endtask

  task automatic test_reset();
    rst_n = 1'b0; up_valid = 1'b1; cfg_eager = 1'b1; cfg_en = 6'h3F;
    set_all_sel(1); down_ready = 6'h00;
    tick(); #1;
    n_checks++;
    if (busy !== 1'b0 || xfer_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_state busy=%b cnt=%0d required busy=0 cnt=0", busy, xfer_cnt);
    end
    n_checks++;
    if (down_valid !== 6'h3F || up_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_outputs dv=%h ur=%b required dv=3f ur=0", down_valid, up_ready);
    end
    n_checks++;
    if (b_busy !== 1'b0 || b_xfer_cnt !== 4'd0) begin
      n_fail++; $display("FAIL reset_b busy=%b cnt=%0d required 0/0", b_busy, b_xfer_cnt);
    end
    rst_n = 1'b1; up_valid = 1'b0;
  endtask

  task automatic test_full_ready();
    do_reset();
    cfg_eager = 1'b1; cfg_en = 6'h3F; set_all_sel(1); down_ready = 6'h3F; up_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      n_checks++;
      if (up_ready !== 1'b1 || down_valid !== 6'h3F) begin
        n_fail++; $display("FAIL full_ready cyc=%0d ur=%b dv=%h required ur=1 dv=3f", c, up_ready, down_valid);
      end
      tick();
    end
    up_valid = 1'b0;
    n_checks++;
    if (xfer_cnt !== 16'd10) begin
      n_fail++; $display("FAIL full_ready_cnt got=%0d required=10", xfer_cnt);
    end
  endtask

  task automatic test_eager_split();
    do_reset();
    cfg_eager = 1'b1; cfg_en = 6'h3F; set_all_sel(1); up_valid = 1'b1; down_ready = 6'h05;
    #1;
    n_checks++;
    if (up_ready !== 1'b0 || down_valid !== 6'h3F) begin
      n_fail++; $display("FAIL split_c1 ur=%b dv=%h required ur=0 dv=3f", up_ready, down_valid);
    end
    tick();
    down_ready = 6'h3A; #1;
    n_checks++;
    if (busy !== 1'b1 || down_valid !== 6'h3A || up_ready !== 1'b1) begin
      n_fail++; $display("FAIL split_c2 busy=%b dv=%h ur=%b required 1/3a/1", busy, down_valid, up_ready);
    end
    tick();
    up_valid = 1'b0; #1;
    n_checks++;
    if (xfer_cnt !== 16'd1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL split_done cnt=%0d busy=%b required 1/0", xfer_cnt, busy);
    end
  endtask

  task automatic test_mask_latch();
    do_reset();
    cfg_eager = 1'b1; cfg_en = 6'h03; set_all_sel(1); up_valid = 1'b1; down_ready = 6'h01;
    tick();
    cfg_en = 6'h3C; set_all_sel(0); down_ready = 6'h00; #1;
    n_checks++;
    if (down_valid !== 6'h02 || busy !== 1'b1 || up_ready !== 1'b0) begin
      n_fail++; $display("FAIL latch_hold dv=%h busy=%b ur=%b required 02/1/0", down_valid, busy, up_ready);
    end
    set_all_sel(1); down_ready = 6'h02; #1;
    n_checks++;
    if (up_ready !== 1'b1 || down_valid !== 6'h02) begin
      n_fail++; $display("FAIL latch_finish ur=%b dv=%h required 1/02", up_ready, down_valid);
    end
    tick();
    down_ready = 6'h00; #1;
    n_checks++;
    if (down_valid !== 6'h3C || busy !== 1'b0) begin
      n_fail++; $display("FAIL latch_next dv=%h busy=%b required 3c/0", down_valid, busy);
    end
    up_valid = 1'b0;
  endtask

  task automatic test_drop();
    do_reset();
    cfg_eager = 1'b1; cfg_en = 6'h3F; set_all_sel(0); down_ready = 6'h00; up_valid = 1'b1;
    #1;
    n_checks++;
    if (up_ready !== 1'b1 || down_valid !== 6'h00) begin
      n_fail++; $display("FAIL drop ur=%b dv=%h required 1/00", up_ready, down_valid);
    end
    tick(); tick();
    up_valid = 1'b0;
    n_checks++;
    if (xfer_cnt !== 16'd2) begin
      n_fail++; $display("FAIL drop_cnt got=%0d required=2", xfer_cnt);
    end
  endtask

  task automatic test_lazy();
    do_reset();
    cfg_eager = 1'b0; cfg_en = 6'h3F; set_all_sel(1); up_valid = 1'b1; down_ready = 6'h1F;
    #1;
    // Only channel 5 sees every other channel ready, so it alone is offered.
    n_checks++;
    if (down_valid !== 6'h20 || up_ready !== 1'b0) begin
      n_fail++; $display("FAIL lazy_c1 dv=%h ur=%b required 20/0", down_valid, up_ready);
    end
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL lazy_busy got=%b required=0", busy);
    end
    down_ready = 6'h3F; #1;
    n_checks++;
    if (down_valid !== 6'h3F || up_ready !== 1'b1) begin
      n_fail++; $display("FAIL lazy_c2 dv=%h ur=%b required 3f/1", down_valid, up_ready);
    end
    tick();
    up_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || xfer_cnt !== 16'd1) begin
      n_fail++; $display("FAIL lazy_end busy=%b cnt=%0d required 0/1", busy, xfer_cnt);
    end
  endtask

  task automatic test_protocol_hold();
    do_reset();
    cfg_eager = 1'b1; cfg_en = 6'h3F; set_all_sel(1); up_valid = 1'b1; down_ready = 6'h0F;
    tick();
    up_valid = 1'b0; cfg_eager = 1'b0; down_ready = 6'h3F;
    tick(); #1;
    n_checks++;
    if (down_valid !== 6'h00 || busy !== 1'b1 || xfer_cnt !== 16'd0) begin
      n_fail++; $display("FAIL hold dv=%h busy=%b cnt=%0d required 00/1/0", down_valid, busy, xfer_cnt);
    end
    up_valid = 1'b1; down_ready = 6'h00; #1;
    n_checks++;
    if (down_valid !== 6'h30 || up_ready !== 1'b0) begin
      n_fail++; $display("FAIL hold_resume dv=%h ur=%b required 30/0", down_valid, up_ready);
    end
    down_ready = 6'h30;
    tick();
    up_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || xfer_cnt !== 16'd1) begin
      n_fail++; $display("FAIL hold_end busy=%b cnt=%0d required 0/1", busy, xfer_cnt);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c % 17 == 0) begin
        cfg_en    = 6'($urandom);
        cfg_eager = 1'($urandom);
        for (int i = 0; i < 6; i++) cfg_sel_idx[i*5 +: 5] = 5'($urandom_range(0, 31));
      end
      for (int i = 0; i < 6; i++) sel_word[i*32 +: 32] = $urandom | $urandom;
      rst_n      = ($urandom_range(0, 79) != 0);
      up_valid   = ($urandom_range(0, 7) != 0);
      down_ready = 6'($urandom);
      #1;
      model_expect();
      n_checks++;
      if (down_valid !== e_dv || up_ready !== e_ur || busy !== m_inflight || xfer_cnt !== 16'(m_cnt)) begin
        n_fail++;
        $display("FAIL random cyc=%0d dv=%h ur=%b busy=%b cnt=%0d required dv=%h ur=%b busy=%b cnt=%0d",
                 c, down_valid, up_ready, busy, xfer_cnt, e_dv, e_ur, m_inflight, m_cnt);
      end
      tick();
    end
    rst_n = 1'b1; up_valid = 1'b0;
  endtask

  task automatic test_dut_b();
    do_reset();
    b_cfg_eager = 1'b1; b_cfg_en = 6'h3F; b_sel_word = '1; b_cfg_sel_idx = '0;
    for (int i = 0; i < 5; i++) b_cfg_sel_idx[i*5 +: 5] = 5'($urandom_range(0, 19));
    b_cfg_sel_idx[25 +: 5] = 5'($urandom_range(20, 31));
    b_down_ready = 6'h3F; b_up_valid = 1'b1; #1;
    n_checks++;
    if (b_down_valid !== 6'h1F || b_up_ready !== 1'b1) begin
      n_fail++; $display("FAIL b_idx_range dv=%h ur=%b required 1f/1", b_down_valid, b_up_ready);
    end
    for (int c = 0; c < 17; c++) tick();
    n_checks++;
    if (b_xfer_cnt !== 4'd1) begin
      n_fail++; $display("FAIL b_wrap got=%0d required=1", b_xfer_cnt);
    end
    b_down_ready = 6'h01;
    tick();
    n_checks++;
    if (b_busy !== 1'b1) begin
      n_fail++; $display("FAIL b_pend got=%b required=1", b_busy);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; b_up_valid = 1'b0; #1;
    n_checks++;
    if (b_busy !== 1'b0 || b_xfer_cnt !== 4'd0) begin
      n_fail++; $display("FAIL b_reset_pend busy=%b cnt=%0d required 0/0", b_busy, b_xfer_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b0; up_valid = 1'b0; sel_word = '0; cfg_en = '0; cfg_sel_idx = '0;
    cfg_eager = 1'b1; down_ready = '0;
    b_up_valid = 1'b0; b_sel_word = '0; b_cfg_en = '0; b_cfg_sel_idx = '0;
    b_cfg_eager = 1'b1; b_down_ready = '0;
    m_inflight = 0; m_need = '0; m_got = '0; m_cnt = 0;
    @(negedge clk);
    test_reset();
    test_full_ready();
    test_eager_split();
    test_mask_latch();
    test_drop();
    test_lazy();
    test_protocol_hold();
    test_random();
    test_dut_b();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
